// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request at a
// time, and loads the IF/ID register. A one-entry buffer keeps a response that
// arrives during Freeze, and redirects discard any response still in flight.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Freeze,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] PC_out,
    output logic        if_valid
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, HOLD} state_t;

    localparam logic [31:0] START_PC = RESET_PC & ~32'h3;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;

    logic        accept;
    logic        new_instr;
    logic [31:0] new_data;
    logic [31:0] br_tgt;
    logic [31:0] seq_pc;

    assign accept    = (state_q == REQ) && imem_ready;
    assign br_tgt    = Branch_addr & ~32'h3;
    assign seq_pc    = fetch_pc_q + 32'd4;  // wraps modulo 2^32
    assign imem_req  = (state_q == REQ);
    assign imem_addr = pc_q;

    // Fetch FSM: next state, PC, captured fetch address and hold buffer.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        hold_d     = hold_q;
        new_instr  = 1'b0;
        new_data   = imem_rdata;
        case (state_q)
            IDLE: begin
                pc_d    = START_PC;
                state_d = REQ;
            end
            REQ: begin
                if (accept) begin
                    if (Branch_taken) begin
                        // Request already left; its response must be drained.
                        pc_d    = br_tgt;
                        state_d = DROP;
                    end else begin
                        fetch_pc_d = pc_q;
                        state_d    = WAIT;
                    end
                end else if (Branch_taken) begin
                    pc_d = br_tgt;
                end
            end
            WAIT: begin
                if (Branch_taken) begin
                    pc_d    = br_tgt;
                    state_d = imem_rvalid ? REQ : DROP;
                end else if (imem_rvalid) begin
                    if (Freeze) begin
                        hold_d  = imem_rdata;
                        state_d = HOLD;
                    end else begin
                        new_instr = 1'b1;
                        pc_d      = seq_pc;
                        state_d   = REQ;
                    end
                end
            end
            DROP: begin
                if (Branch_taken) pc_d = br_tgt;
                if (imem_rvalid) state_d = REQ;
            end
            HOLD: begin
                if (Branch_taken) begin
                    pc_d    = br_tgt;
                    state_d = REQ;
                end else if (!Freeze) begin
                    new_instr = 1'b1;
                    new_data  = hold_q;
                    pc_d      = seq_pc;
                    state_d   = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // IF/ID register: branch flush beats freeze, which beats a new instruction.
    always_comb begin
        instr_d  = 32'h0;
        pc_out_d = pc_out_q;
        valid_d  = 1'b0;
        if (Branch_taken) begin
            pc_out_d = 32'h0;
        end else if (Freeze) begin
            instr_d = instr_q;
            valid_d = valid_q;
        end else if (new_instr) begin
            instr_d  = new_data;
            pc_out_d = seq_pc;
            valid_d  = 1'b1;
        end
    end

    // State and pipeline registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= START_PC;
            fetch_pc_q <= START_PC;
            hold_q     <= 32'h0;
            instr_q    <= 32'h0;
            pc_out_q   <= 32'h0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            hold_q     <= hold_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            valid_q    <= valid_d;
        end
    end

    assign instruction = instr_q;
    assign PC_out      = pc_out_q;
    assign if_valid    = valid_q;

endmodule
